// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the shift-amount width helper
// used by the ALU core and the pipeline wrapper.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_N = 3;
  localparam int NFLAGS = 4;

  function automatic int shw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: eight operations with carry/zero/overflow/negative flags.
// Add/sub and shifts are computed one bit wider so carry and shift-out fall out directly.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [2:0]        i_sel,
  output logic [WIDTH-1:0]  o_res,
  output logic [NFLAGS-1:0] o_flags
);

  localparam int SHW = shw(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [SHW-1:0]   w_s;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_sra;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_o;

  assign w_s    = i_b[SHW-1:0];
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  // Left shift spills the last shifted-out bit into bit WIDTH; right shifts into bit 0.
  assign w_shl  = {1'b0, i_a} << w_s;
  assign w_shr  = {i_a, 1'b0} >> w_s;
  assign w_sra  = $unsigned($signed({i_a, 1'b0}) >>> w_s);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    case (i_sel)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_o   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_o   = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      OP_AND: w_res = i_a & i_b;
      OP_OR:  w_res = i_a | i_b;
      OP_XOR: w_res = i_a ^ i_b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      default: ;
    endcase
  end

  assign o_res           = w_res;
  assign o_flags[FLAG_C] = w_c;
  assign o_flags[FLAG_Z] = (w_res == '0);
  assign o_flags[FLAG_O] = w_o;
  assign o_flags[FLAG_N] = w_res[MSB];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds operands, S2 holds result and flags.
// Back-pressure ripples combinationally from out_ready to in_ready; sticky_v accumulates overflow.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_o,
  output logic             flag_n,
  output logic             sticky_v,
  input  logic             clr_sticky
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_sel;

  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_res;
  logic [NFLAGS-1:0] r_flags;

  logic [WIDTH-1:0]  w_core_res;
  logic [NFLAGS-1:0] w_core_flags;
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_out_xfer;

  // Handshake: a beat moves when valid && ready on the same rising edge. A stage
  // may load whenever it is empty or its contents leave on that edge; once valid,
  // a stage's payload holds until it transfers.
  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign in_ready   = w_s1_adv;
  assign w_out_xfer = r_s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
    end
  end

  // Operand payload carries no reset: it is only consumed alongside r_s1_valid.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_s1_a   <= opA;
      r_s1_b   <= opB;
      r_s1_sel <= sel;
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .i_sel  (r_s1_sel),
    .o_res  (w_core_res),
    .o_flags(w_core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_flags    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res   <= w_core_res;
        r_flags <= w_core_flags;
      end
    end
  end

  generate
    if (STICKY) begin : g_sticky
      logic r_sticky;
      // Setting on a delivered overflow takes priority over a same-cycle clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sticky <= 1'b0;
        end else if (w_out_xfer && r_flags[FLAG_O]) begin
          r_sticky <= 1'b1;
        end else if (clr_sticky) begin
          r_sticky <= 1'b0;
        end
      end
      assign sticky_v = r_sticky;
    end else begin : g_no_sticky
      assign sticky_v = 1'b0;
    end
  endgenerate

  assign out_valid = r_s2_valid;
  assign res       = r_res;
  assign flag_c    = r_flags[FLAG_C];
  assign flag_z    = r_flags[FLAG_Z];
  assign flag_o    = r_flags[FLAG_O];
  assign flag_n    = r_flags[FLAG_N];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16): directed vectors, an arithmetic reference model
// feeding an expected queue, and one compare process checking every output cycle.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic        flag_c;
  logic        flag_z;
  logic        flag_o;
  logic        flag_n;
  logic        sticky_v;
  logic        clr_sticky;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  logic        model_sticky = 1'b0;
  logic        saw_stall = 1'b0;
  int          n_delivered = 0;

  alu_pipe #(.WIDTH(16), .STICKY(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_o    (flag_o),
    .flag_n    (flag_n),
    .sticky_v  (sticky_v),
    .clr_sticky(clr_sticky)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model from the opcode rules, packed as {c,z,o,n,res}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    int ua, ub, sa, sb, full, s;
    logic [15:0] r;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = ub % 16;
    r  = '0;
    c  = 1'b0;
    o  = 1'b0;
    case (op)
      3'd0: begin
        full = ua + ub;
        r = full[15:0];
        c = (full > 65535);
        o = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      3'd1: begin
        full = ua - ub;
        r = full[15:0];
        c = (ua < ub);
        o = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = 16'(ua << s);
        c = (s != 0) && (((ua >> (16 - s)) & 1) != 0);
      end
      3'd6: begin
        r = 16'(ua >> s);
        c = (s != 0) && (((ua >> (s - 1)) & 1) != 0);
      end
      default: begin
        r = 16'(sa >>> s);
        c = (s != 0) && (((ua >> (s - 1)) & 1) != 0);
      end
    endcase
    return {c, (r == 16'h0000), o, r[15], r};
  endfunction

  // driver tasks
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    bit done = 1'b0;
    opA = a;
    opB = b;
    sel = op;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (in_ready) begin
        done = 1'b1;
        exp_q.push_back(model(a, b, op));
      end else begin
        saw_stall = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #3;
  endtask

  // scoreboard: compares every cycle outputs are meaningful, just before the edge
  initial begin
    logic [19:0] got;
    logic [19:0] prev_got;
    logic        stalled_prev;
    logic        set_now;
    prev_got = '0;
    stalled_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("reset_outputs", 32'({out_valid, flag_c, flag_z, flag_o, flag_n, res, sticky_v}), 32'd0);
        stalled_prev = 1'b0;
      end else begin
        set_now = 1'b0;
        got = {flag_c, flag_z, flag_o, flag_n, res};
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'd1, 32'd0);
          end else begin
            check("result", 32'(got), 32'(exp_q[0]));
            if (stalled_prev) check("hold_stable", 32'(got), 32'(prev_got));
            if (out_ready) begin
              set_now = exp_q[0][17];
              void'(exp_q.pop_front());
              n_delivered++;
            end
          end
        end
        check("sticky_v", 32'(sticky_v), 32'(model_sticky));
        if (set_now) model_sticky = 1'b1;
        else if (clr_sticky) model_sticky = 1'b0;
        stalled_prev = out_valid && !out_ready;
        prev_got = got;
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0;
    in_valid = 1'b0;
    opA = '0;
    opB = '0;
    sel = '0;
    out_ready = 1'b1;
    clr_sticky = 1'b0;

    // Pin the model to hand-computed results.
    check("m_add_carry", 32'(model(16'hFFFF, 16'h0001, 3'd0)), 32'h000C0000);
    check("m_add_ovf",   32'(model(16'h7FFF, 16'h0001, 3'd0)), 32'h00038000);
    check("m_sub_borrow",32'(model(16'h0003, 16'h0005, 3'd1)), 32'h0009FFFE);
    check("m_sub_ovf",   32'(model(16'h8000, 16'h0001, 3'd1)), 32'h00027FFF);
    check("m_sra",       32'(model(16'h8001, 16'h0001, 3'd7)), 32'h0009C000);
    check("m_shl",       32'(model(16'h8000, 16'h0001, 3'd5)), 32'h000C0000);
    check("m_shr0",      32'(model(16'h1234, 16'h0010, 3'd6)), 32'h00001234);
    check("m_xor",       32'(model(16'hF0F0, 16'hFF00, 3'd4)), 32'h00000FF0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("out_valid_after_reset", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Latency: offered this cycle, visible on out_valid two cycles on.
    send(16'hFFFF, 16'h0001, 3'd0);
    #3;
    check("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #3;
    check("latency_valid", 32'(out_valid), 32'd1);
    check("add_carry_dut", 32'({flag_c, flag_z, flag_o, flag_n, res}), 32'h000C0000);
    drain();

    send(16'h7FFF, 16'h0001, 3'd0);
    drain();
    check("sticky_set", 32'(sticky_v), 32'd1);
    repeat (3) @(negedge clk);
    #3;
    check("sticky_holds", 32'(sticky_v), 32'd1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    #3;
    check("sticky_cleared", 32'(sticky_v), 32'd0);
    @(negedge clk);

    // Back-to-back directed vectors across every opcode.
    send(16'h0003, 16'h0005, 3'd1);
    send(16'h8000, 16'h0001, 3'd1);
    send(16'h8001, 16'h0001, 3'd7);
    send(16'h8000, 16'h0001, 3'd5);
    send(16'h1234, 16'h0010, 3'd6);
    send(16'hF0F0, 16'hFF00, 3'd2);
    send(16'hF0F0, 16'h0F0F, 3'd3);
    send(16'hF0F0, 16'hFF00, 3'd4);
    send(16'hA5A5, 16'h0004, 3'd6);
    send(16'h4000, 16'h4000, 3'd0);
    drain();
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    @(negedge clk);

    // Overflow delivered in the same cycle as a clear: the set must win.
    out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 3'd0);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    #3;
    check("sticky_set_beats_clear", 32'(sticky_v), 32'd1);
    drain();

    // Back-pressure mid-stream.
    saw_stall = 1'b0;
    base = n_delivered;
    fork
      begin
        send(16'h0001, 16'h0002, 3'd0);
        send(16'h0010, 16'h0003, 3'd1);
        send(16'h00FF, 16'h0F0F, 3'd2);
        send(16'h1000, 16'h0003, 3'd5);
        send(16'hFFF0, 16'h0002, 3'd7);
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("in_ready_fell", 32'(saw_stall), 32'd1);
    check("bp_delivered", 32'(n_delivered - base), 32'd5);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 3'd0);
    send(16'h0002, 16'h0002, 3'd0);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    model_sticky = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_flags", 32'({flag_c, flag_z, flag_o, flag_n, res}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("no_stale_beat", 32'(out_valid), 32'd0);
    check("in_ready_post_rst", 32'(in_ready), 32'd1);

    send(16'h0005, 16'h0003, 3'd1);
    drain();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
